// File: rtl/shift_xor_ctrl.sv
// Sequencer for the WIDTH-stage shift-and-xor chain: it loads a word LSB-first with
// its key, drains the chain while capturing the result serially, then hands the result off.
module shift_xor_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_key,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [CNT_W-1:0] jobs_done,
  output logic             sr_data_in,
  output logic             sr_xor_in,
  input  logic             sr_data_out
);

  localparam int CW = $clog2(2*WIDTH);
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0] W_C       = CW'(WIDTH);
  localparam logic [CW-1:0] LOAD_LAST = CW'(WIDTH-1);
  localparam logic [CW-1:0] LAST_C    = CW'(2*WIDTH-1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] data_q, key_q, res, res_next;

  // The same bit index walks the data in LOAD and the key/result in DRAIN.
  always_comb begin
    idx = IW'(cnt);
    if (state == S_DRAIN) idx = IW'(cnt - W_C);
    res_next      = res;
    res_next[idx] = sr_data_out;
  end

  assign in_ready   = (state == S_IDLE);
  assign busy       = (state == S_LOAD) || (state == S_DRAIN);
  assign out_valid  = (state == S_DONE);
  assign sr_data_in = (state == S_LOAD) ? data_q[idx] : 1'b0;
  assign sr_xor_in  = busy ? key_q[idx] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      data_q    <= '0;
      key_q     <= '0;
      res       <= '0;
      out_data  <= '0;
      jobs_done <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && !abort) begin
            data_q <= in_data;
            key_q  <= in_key;
            cnt    <= '0;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == LOAD_LAST) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            res <= res_next;
            if (cnt == LAST_C) begin
              // out_data only changes here, so it stays stable through DONE and after.
              out_data <= res_next;
              cnt      <= '0;
              state    <= S_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (out_ready) begin
            state     <= S_IDLE;
            jobs_done <= jobs_done + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_xor_ctrl.sv
// Bench for shift_xor_ctrl: drives it against a behavioural chain and checks results
// against out = data ^ {WIDTH{^key}} plus handshake, abort and reset corner cases.
module tb_shift_xor_ctrl;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;  // narrow counter so the wrap case stays short

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, abort, out_valid, out_ready, busy;
  logic [WIDTH-1:0] in_data, in_key, out_data;
  logic [CNT_W-1:0] jobs_done;
  logic sr_data_in, sr_xor_in, sr_data_out;

  always #5 clk = ~clk;

  shift_xor_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .jobs_done(jobs_done),
    .sr_data_in(sr_data_in), .sr_xor_in(sr_xor_in), .sr_data_out(sr_data_out)
  );

  // Chain: every stage xors in xor_in as it shifts; never reset, starts with junk.
  logic [WIDTH-1:0] chain = 8'h6B;
  always @(posedge clk) chain <= {chain[WIDTH-2:0] ^ {(WIDTH-1){sr_xor_in}}, sr_data_in ^ sr_xor_in};
  assign sr_data_out = chain[WIDTH-1];

  int total = 0, bad = 0;
  int jobs_m = 0;

  typedef struct { logic [7:0] d; logic [7:0] k; logic [7:0] exp; } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] model(input logic [7:0] d, input logic [7:0] k);
    int p = 0;
    for (int i = 0; i < 8; i++) p += k[i];
    return (p % 2 == 1) ? ~d : d;
  endfunction

  // Leaves the bench in cycle 1 (first LOAD cycle) after the accept edge.
  task automatic start_job(input logic [7:0] d, input logic [7:0] k);
    int n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    check("in_ready_before_job", in_ready, 1);
    in_valid = 1; in_data = d; in_key = k;
    tick();
    in_valid = 0; in_data = 8'($urandom); in_key = 8'($urandom);
  endtask

  task automatic run_job(input logic [7:0] d, input logic [7:0] k,
                         output logic [7:0] res, output logic [7:0] seq, output int lat);
    start_job(d, k);
    check("busy_in_load", busy, 1);
    lat = 1; seq = 0;
    for (int i = 0; i < 8; i++) begin seq[i] = sr_data_in; tick(); lat++; end
    while (!out_valid && lat < 60) begin tick(); lat++; end
    res = out_data;
  endtask

  task automatic handoff();
    out_ready = 1; tick(); out_ready = 0;
    jobs_m = (jobs_m + 1) % (1 << CNT_W);
    check("out_valid_after_handoff", out_valid, 0);
    check("jobs_done", jobs_done, jobs_m);
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
    jobs_m = 0;
  endtask

  initial begin
    logic [7:0] res, seq, d, k;
    int lat, cyc, last, done_cnt, seen;
    rst = 1; in_valid = 0; in_data = 0; in_key = 0; abort = 0; out_ready = 0;
    vecs[0] = '{8'hA5, 8'h01, 8'h5A};
    vecs[1] = '{8'hA5, 8'h03, 8'hA5};
    vecs[2] = '{8'hA5, 8'hFE, 8'h5A};
    vecs[3] = '{8'h3C, 8'h80, 8'hC3};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF};
    vecs[5] = '{8'h00, 8'hFF, 8'h00};
    vecs[6] = '{8'h81, 8'h7F, 8'h7E};
    do_reset();

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_busy", busy, 0);
    check("rst_sr_bits", {sr_data_in, sr_xor_in}, 0);

    // First job: LOAD pattern, latency, result, counter.
    run_job(8'hA5, 8'h00, res, seq, lat);
    check("load_sequence", seq, 8'hA5);
    check("latency", lat, 17);
    check("result_a5_00", res, 8'hA5);
    handoff();

    foreach (vecs[i]) begin
      run_job(vecs[i].d, vecs[i].k, res, seq, lat);
      check("table_result", res, vecs[i].exp);
      check("table_latency", lat, 17);
      handoff();
    end

    // Hold the result while a second request is presented; it must be ignored.
    run_job(8'hA5, 8'h01, res, seq, lat);
    in_valid = 1; in_data = 8'h00; in_key = 8'h00;
    for (int i = 0; i < 10; i++) begin
      check("hold_out_data", out_data, 8'h5A);
      check("hold_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 0;
    handoff();
    tick(); tick();
    check("ignored_request_busy", busy, 0);
    check("ignored_request_out_data", out_data, 8'h5A);

    // Abort at LOAD cnt=3.
    start_job(8'h11, 8'h22);
    tick(); tick(); tick();
    abort = 1; tick(); abort = 0;
    check("abort_load_idle", in_ready, 1);
    check("abort_load_sr", {sr_data_in, sr_xor_in}, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin seen += out_valid; tick(); end
    check("abort_no_result", seen, 0);
    check("abort_jobs_unchanged", jobs_done, jobs_m);
    run_job(8'h3C, 8'h80, res, seq, lat);
    check("after_abort_result", res, 8'hC3);
    handoff();

    // Abort mid-DRAIN.
    start_job(8'h55, 8'h0F);
    for (int i = 0; i < 11; i++) tick();
    check("drain_busy", busy, 1);
    abort = 1; tick(); abort = 0;
    check("abort_drain_busy", busy, 0);
    check("abort_drain_sr", {sr_data_in, sr_xor_in}, 0);

    // Abort in DONE discards the result.
    run_job(8'h0F, 8'h01, res, seq, lat);
    check("pre_abort_done_valid", out_valid, 1);
    abort = 1; out_ready = 1; tick(); abort = 0; out_ready = 0;
    check("abort_done_valid", out_valid, 0);
    check("abort_done_jobs", jobs_done, jobs_m);

    // Abort wins over in_valid in IDLE.
    abort = 1; in_valid = 1; tick(); abort = 0; in_valid = 0;
    check("abort_idle_no_accept", in_ready, 1);

    // Reset mid-DRAIN; chain keeps stale contents.
    start_job(8'hC7, 8'h5D);
    for (int i = 0; i < 11; i++) tick();
    rst = 1; tick(); rst = 0; jobs_m = 0;
    check("rst_drain_idle", in_ready, 1);
    check("rst_drain_out_valid", out_valid, 0);
    check("rst_drain_jobs", jobs_done, 0);
    run_job(8'hFF, 8'h00, res, seq, lat);
    check("stale_chain_result", res, 8'hFF);
    handoff();

    // Handoff and request in the same cycle: accept happens one cycle later.
    run_job(8'h12, 8'h34, res, seq, lat);
    out_ready = 1; in_valid = 1; in_data = 8'h9A; in_key = 8'h01;
    tick(); out_ready = 0;
    jobs_m++;
    check("same_cycle_handoff_jobs", jobs_done, jobs_m);
    check("same_cycle_idle", in_ready, 1);
    tick(); in_valid = 0;
    check("same_cycle_accept_late", busy, 1);
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    check("same_cycle_result", out_data, 8'h65);
    handoff();

    // Random jobs against the model.
    for (int j = 0; j < 40; j++) begin
      d = 8'($urandom); k = 8'($urandom);
      run_job(d, k, res, seq, lat);
      check("rand_result", res, model(d, k));
      check("rand_latency", lat, 17);
      for (int h = $urandom_range(0, 3); h > 0; h--) tick();
      handoff();
    end

    // Back-to-back jobs until the counter wraps.
    do_reset();
    in_valid = 1; out_ready = 1; in_data = 8'h3C; in_key = 8'h80;
    cyc = 0; last = -1; done_cnt = 0;
    while (done_cnt < (1 << CNT_W) + 1 && cyc < ((1 << CNT_W) + 1) * 18 + 100) begin
      if (in_ready) begin
        if (last >= 0) check("b2b_spacing", cyc - last, 18);
        last = cyc;
      end
      if (out_valid) begin
        check("b2b_result", out_data, 8'hC3);
        done_cnt++;
      end
      tick(); cyc++;
    end
    in_valid = 0; out_ready = 0;
    check("b2b_job_count", done_cnt, (1 << CNT_W) + 1);
    check("b2b_jobs_wrap", jobs_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
